// File: rtl/cnt_pkg.sv
// rtl/cnt_pkg.sv - shared types and constants for the counted-burst stream; CNT_SINK_TIMEOUT_EN adds the TMO state
package cnt_pkg;

  localparam int DLEN_W = 32;
  localparam int TMO_W  = 16;

`ifdef CNT_SINK_TIMEOUT_EN
  localparam int ST_W = 6;
`else
  localparam int ST_W = 5;
`endif

  typedef enum logic [ST_W-1:0] {
    S_IDLE    = ST_W'(1),
    S_ARMED   = ST_W'(2),
    S_CAPTURE = ST_W'(4),
    S_CHECK   = ST_W'(8),
    S_DONE    = ST_W'(16)
`ifdef CNT_SINK_TIMEOUT_EN
    , S_TMO   = ST_W'(32)
`endif
  } state_t;

  // Beat counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [DLEN_W-1:0] sat_inc(input logic [DLEN_W-1:0] v);
    return (v == '1) ? v : v + DLEN_W'(1);
  endfunction

endpackage

// File: rtl/cnt_sink_if.sv
// rtl/cnt_sink_if.sv - beat stream between the burst producer and the sink
interface cnt_sink_if #(
  parameter int DW = 32
);
  logic          IN_VALID;
  logic [DW-1:0] IN_DATA;
  logic          IN_DONE;
  logic          IN_READY;

  modport master (output IN_VALID, output IN_DATA, output IN_DONE, input IN_READY);
  modport slave  (input IN_VALID, input IN_DATA, input IN_DONE, output IN_READY);
endinterface

// File: rtl/cnt_sink_cdc_sync.sv
// rtl/cnt_sink_cdc_sync.sv - multi-flop synchronizer for a single-bit level
module cnt_sink_cdc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // Shift the asynchronous level through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/cnt_sink.sv
// rtl/cnt_sink.sv - counted-burst sink with sum and length check; CNT_SINK_TIMEOUT_EN enables the idle timeout
module cnt_sink
  import cnt_pkg::*;
#(
  parameter int DW           = 32,
  parameter int SYNC_REG_LEN = 2
`ifdef CNT_SINK_TIMEOUT_EN
  , parameter int TIMEOUT    = 1024
`endif
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ARM,
  input  logic [DLEN_W-1:0] DLEN,
  cnt_sink_if.slave         bus,
  output logic              BUSY,
  output logic              CAP_DONE,
  output logic [DLEN_W-1:0] BEAT_CNT,
  output logic [31:0]       SUM,
  output logic              ERR_SHORT,
  output logic              ERR_LONG,
  output logic              ERR_TMO
);

  state_t            state;
  logic              arm_s;
  logic              token;
  logic              in_ready;
  logic [DLEN_W-1:0] dlen_q1;
  logic [DLEN_W-1:0] dlen_q2;
  logic [DLEN_W-1:0] dlen_lat;
  logic [DW-1:0]     data;
  logic [31:0]       data_ext;

  assign data     = bus.IN_DATA;
  assign data_ext = 32'(data);
  assign bus.IN_READY = in_ready;

`ifdef CNT_SINK_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);
  logic [TMO_W-1:0] idle_cnt;
`else
  assign ERR_TMO = 1'b0;
`endif

  cnt_sink_cdc_sync #(.STAGES(SYNC_REG_LEN)) u_arm_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (ARM),
    .q     (arm_s)
  );

  // DLEN is quasi-static; two flops settle it before the arm edge samples it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dlen_q1 <= '0;
      dlen_q2 <= '0;
    end else begin
      dlen_q1 <= DLEN;
      dlen_q2 <= dlen_q1;
    end
  end

  // Capture FSM: arm, accumulate beats, check length, hold results.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      token     <= 1'b0;
      in_ready  <= 1'b0;
      BUSY      <= 1'b0;
      CAP_DONE  <= 1'b1;
      BEAT_CNT  <= '0;
      SUM       <= '0;
      ERR_SHORT <= 1'b0;
      ERR_LONG  <= 1'b0;
      dlen_lat  <= '0;
`ifdef CNT_SINK_TIMEOUT_EN
      ERR_TMO   <= 1'b0;
      idle_cnt  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          token <= arm_s;
          if (arm_s && !token) begin
            dlen_lat  <= dlen_q2;
            BEAT_CNT  <= '0;
            SUM       <= '0;
            ERR_SHORT <= 1'b0;
            ERR_LONG  <= 1'b0;
            CAP_DONE  <= 1'b0;
            BUSY      <= 1'b1;
            in_ready  <= 1'b1;
            state     <= S_ARMED;
`ifdef CNT_SINK_TIMEOUT_EN
            ERR_TMO   <= 1'b0;
            idle_cnt  <= '0;
`endif
          end
        end
        S_ARMED, S_CAPTURE: begin
          if (bus.IN_VALID && in_ready) begin
            BEAT_CNT <= sat_inc(BEAT_CNT);
            SUM      <= SUM + data_ext;
            state    <= S_CAPTURE;
`ifdef CNT_SINK_TIMEOUT_EN
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + TMO_W'(1);
            if (idle_cnt + TMO_W'(1) == TMO_LIMIT) begin
              state <= S_TMO;
            end
`endif
          end
          // End of burst overrides both the capture and the timeout path.
          if (bus.IN_DONE) begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          ERR_SHORT <= (BEAT_CNT < dlen_lat);
          ERR_LONG  <= (BEAT_CNT > dlen_lat);
          in_ready  <= 1'b0;
          BUSY      <= 1'b0;
          CAP_DONE  <= 1'b1;
          state     <= S_DONE;
        end
`ifdef CNT_SINK_TIMEOUT_EN
        S_TMO: begin
          ERR_TMO  <= 1'b1;
          in_ready <= 1'b0;
          BUSY     <= 1'b0;
          CAP_DONE <= 1'b1;
          state    <= S_DONE;
        end
`endif
        default: begin
          state    <= S_IDLE;
          token    <= 1'b0;
          in_ready <= 1'b0;
          BUSY     <= 1'b0;
          CAP_DONE <= 1'b1;
        end
      endcase
    end
  end

endmodule
